// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - op codes, FSM states and lane constants for load_store_unit
package lsu_pkg;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b011;
  localparam logic [2:0] LSU_LHU = 3'b100;
  localparam logic [2:0] LSU_SB  = 3'b101;
  localparam logic [2:0] LSU_SH  = 3'b110;
  localparam logic [2:0] LSU_SW  = 3'b111;

  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } lsu_state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  // Halfword ops need an even address, word ops a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: return off[0];
      LSU_LW, LSU_SW:          return off != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-aligned dataMemory bus between load_store_unit and memory
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_addr, mem_write_data, mem_read, mem_write, mem_write_en,
    input  mem_read_data
  );

  modport slave (
    input  mem_addr, mem_write_data, mem_read, mem_write, mem_write_en,
    output mem_read_data
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane extract/extend for loads and lane merge for stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [LANE_W-1:0]   lane;
  logic [2*LANE_W-1:0] half;

  // Without alignment checking, addr[0] is ignored for halfwords and addr[1:0] for words.
  always_comb begin
    lane = word[{off, 3'b000} +: LANE_W];
    half = off[1] ? word[31:16] : word[15:0];

    load_val = word;
    case (op)
      LSU_LB:  load_val = {{24{lane[7]}}, lane};
      LSU_LH:  load_val = {{16{half[15]}}, half};
      LSU_LBU: load_val = {24'h0, lane};
      LSU_LHU: load_val = {16'h0, half};
      default: load_val = word;
    endcase

    merged = word;
    case (op)
      LSU_SB: merged[{off, 3'b000} +: LANE_W] = store_data[LANE_W-1:0];
      LSU_SH: begin
        if (off[1]) merged[31:16] = store_data[15:0];
        else        merged[15:0]  = store_data[15:0];
      end
      default: merged = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store sequencer; LSU_ALIGN_CHECK_EN enables misalign traps
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              misalign,
  load_store_unit_if.master mem
);

  lsu_state_t        state_q, state_d;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [DATA_W-1:0] load_q;
  logic [31:0]       load_val;
  logic [31:0]       merged;
  logic              bad;
  logic              accept;

  assign accept = (state_q == IDLE) && start;

`ifdef LSU_ALIGN_CHECK_EN
  logic misalign_q;
  assign bad      = is_misaligned(op, addr[1:0]);
  assign misalign = misalign_q;
`else
  assign bad      = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bad)                 state_d = DONE;
          else if (op == LSU_SW)   state_d = WR;
          else                     state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = is_store(op_q) ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      op_q    <= '0;
      off_q   <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      maddr_q <= '0;
      load_q  <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q    <= op;
        off_q   <= addr[1:0];
        data_q  <= store_data;
        maddr_q <= {addr[ADDR_W-1:2], 2'b00};
        if (op == LSU_SW) wdata_q <= store_data;
`ifdef LSU_ALIGN_CHECK_EN
        misalign_q <= bad;
`endif
      end
      // Read data arrives during CAP: loads register the result, sub-word stores build the write word.
      if (state_q == CAP) begin
        if (is_store(op_q)) wdata_q <= merged;
        else                load_q  <= load_val;
      end
    end
  end

  lsu_align u_align (
    .op         (op_q),
    .off        (off_q),
    .word       (mem.mem_read_data),
    .store_data (data_q),
    .load_val   (load_val),
    .merged     (merged)
  );

  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE);
  assign load_data          = load_q;
  assign mem.mem_addr       = maddr_q;
  assign mem.mem_write_data = wdata_q;
  assign mem.mem_read       = (state_q == RD);
  assign mem.mem_write      = (state_q == WR);
  assign mem.mem_write_en   = (state_q == WR);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a word memory model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, misalign;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] mem [0:63];

  load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk        (clk),
    .Rst        (rst_n),
    .start      (start),
    .op         (op),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .misalign   (misalign),
    .mem        (mif)
  );

  always #5 clk = ~clk;

  // Synchronous dataMemory: read data valid the cycle after mem_read.
  always @(posedge clk) begin
    if (mif.mem_read) begin
      mif.mem_read_data <= mem[mif.mem_addr[7:2]];
      rd_cnt <= rd_cnt + 1;
    end
    if (mif.mem_write && mif.mem_write_en) begin
      mem[mif.mem_addr[7:2]] <= mif.mem_write_data;
      last_wr_addr <= mif.mem_addr;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request, scrambles the inputs after acceptance, and returns the latency to done.
  task automatic run_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] ld, output logic mis);
    @(negedge clk);
    start = 1'b1; op = o; addr = a; store_data = d;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; addr = 32'hFFFF_FFFC; store_data = 32'h0;
    lat = 0; ld = 32'hX; mis = 1'bX;
    for (int n = 1; n <= 8; n++) begin
      if (done) begin
        lat = n; ld = load_data; mis = misalign;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  int          lat;
  logic [31:0] ld;
  logic        mis;
  int          rd0, wr0, dn0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[8]  = 32'h8899AABB;
    mem[17] = 32'h11223344;
    mif.mem_read_data = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("rst_strobes", {29'h0, mif.mem_read, mif.mem_write, mif.mem_write_en}, 32'h0);
    check("rst_mem_addr", mif.mem_addr, 32'h0);
    check("rst_wdata", mif.mem_write_data, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    run_req(3'b000, 32'h21, 32'h0, lat, ld, mis);
    check("lb_lat", lat, 3);
    check("lb_data", ld, 32'hFFFFFFAA);
    run_req(3'b011, 32'h23, 32'h0, lat, ld, mis);
    check("lbu_data", ld, 32'h00000088);
    run_req(3'b001, 32'h22, 32'h0, lat, ld, mis);
    check("lh_data", ld, 32'hFFFF8899);
    run_req(3'b100, 32'h20, 32'h0, lat, ld, mis);
    check("lhu_data", ld, 32'h0000AABB);
    run_req(3'b010, 32'h20, 32'h0, lat, ld, mis);
    check("lw_lat", lat, 3);
    check("lw_data", ld, 32'h8899AABB);
    check("lw_misalign", {31'h0, mis}, 32'h0);

    rd0 = rd_cnt; wr0 = wr_cnt;
    run_req(3'b111, 32'h40, 32'h12345678, lat, ld, mis);
    check("sw_lat", lat, 2);
    check("sw_reads", rd_cnt - rd0, 0);
    check("sw_writes", wr_cnt - wr0, 1);
    check("sw_addr", last_wr_addr, 32'h40);
    check("sw_mem", mem[16], 32'h12345678);
    check("sw_keeps_load_data", load_data, 32'h8899AABB);
    run_req(3'b010, 32'h40, 32'h0, lat, ld, mis);
    check("lw_readback", ld, 32'h12345678);

    rd0 = rd_cnt; wr0 = wr_cnt;
    run_req(3'b101, 32'h41, 32'hFFFFFFEE, lat, ld, mis);
    check("sb_lat", lat, 4);
    check("sb_reads", rd_cnt - rd0, 1);
    check("sb_writes", wr_cnt - wr0, 1);
    check("sb_mem", mem[16], 32'h1234EE78);
    run_req(3'b110, 32'h42, 32'h0000BEEF, lat, ld, mis);
    check("sh_lat", lat, 4);
    check("sh_mem", mem[16], 32'hBEEFEE78);
    run_req(3'b000, 32'h43, 32'h0, lat, ld, mis);
    check("lb_lane3", ld, 32'hFFFFFFBE);

    rd0 = rd_cnt; wr0 = wr_cnt;
    run_req(3'b010, 32'h42, 32'h0, lat, ld, mis);
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_lat", lat, 1);
    check("mis_flag", {31'h0, mis}, 32'h1);
    check("mis_no_read", rd_cnt - rd0, 0);
    check("mis_no_write", wr_cnt - wr0, 0);
    check("mis_load_data", ld, 32'hFFFFFFBE);
    run_req(3'b000, 32'h40, 32'h0, lat, ld, mis);
    check("mis_cleared", {31'h0, mis}, 32'h0);
`else
    check("unal_lw_lat", lat, 3);
    check("unal_lw_data", ld, 32'hBEEFEE78);
    check("unal_lw_flag", {31'h0, mis}, 32'h0);
    check("unal_lw_reads", rd_cnt - rd0, 1);
`endif

    // Reset asserted during the WR cycle of an SB.
    dn0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = 3'b101; addr = 32'h44; store_data = 32'h55;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_wr", {30'h0, mif.mem_write, mif.mem_write_en}, 32'h3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_strobes", {29'h0, mif.mem_read, mif.mem_write, mif.mem_write_en}, 32'h0);
    check("abort_load_data", load_data, 32'h0);
    check("abort_no_done", done_cnt - dn0, 0);
    @(negedge clk); rst_n = 1'b1;

    // start held high while busy must not launch a second request.
    dn0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = 3'b010; addr = 32'h20; store_data = 32'h0;
    @(posedge clk); #1;
    check("hold_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_done", {31'h0, done}, 32'h1);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("hold_one_done", done_cnt - dn0, 1);
    check("hold_idle", {31'h0, busy}, 32'h0);
    check("hold_data", load_data, 32'h8899AABB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
